dram_sipo_rx: RTL and testbench

Serial-to-parallel receiver for the controller's internal serial links; the receive-side counterpart of the PISO transmitter. It captures one bit per `shift` strobe, LSB first, and assembles WIDTH-bit words. Completed words are presented on a valid/ready output port through a single-entry holding register. It sits between the serial data pin logic and the command/data word consumers.

---
 rtl/dram_pkg.sv | 17 +
 rtl/dram_bit_counter.sv | 36 +++
 rtl/dram_sipo_rx.sv | 154 +++++++++++++++
 tb/tb_dram_sipo_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM controller serial links: SIPO receiver state and parity helper.
// Parity support in the receiver is enabled with the DRAM_SIPO_PARITY_EN macro.
package dram_pkg;

  localparam int SIPO_MAX_WIDTH = 64;

  typedef enum logic {
    DATA   = 1'b0,
    PARITY = 1'b1
  } sipo_state_t;

  // Even parity check: 1 means the word plus its parity bit has an odd number of ones.
  function automatic logic even_parity(input logic [SIPO_MAX_WIDTH-1:0] word, input logic pbit);
    return (^word) ^ pbit;
  endfunction

endpackage

// File: rtl/dram_bit_counter.sv
// Modulo-N counter with increment, synchronous clear and wrap strobe.
// Shared between the serial receive and transmit paths.
module dram_bit_counter
  import dram_pkg::*;
#(
  parameter int N = 8,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          i_clear,
  input  logic          i_inc,
  output logic [CW-1:0] o_count,
  output logic          o_wrap
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last  = (r_count == LAST);
  assign o_wrap  = i_inc & ~i_clear & w_last;
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= w_last ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/dram_sipo_rx.sv
// Serial-to-parallel receiver: LSB-first bit capture into WIDTH-bit words with a valid/ready holding register.
// Define DRAM_SIPO_PARITY_EN to expect one even-parity bit after each word.
module dram_sipo_rx
  import dram_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clear,
  input  logic             shift,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sipo_state_t      r_state;
  sipo_state_t      w_state_next;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_shifted;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_accept;
  logic             w_data_bit;
  logic             w_wrap;
  logic             w_complete;
  logic             w_take;
  logic [CW-1:0]    w_count;

  assign w_accept       = shift & ~clear;
  assign w_data_bit     = w_accept & (r_state == DATA);
  assign w_sreg_shifted = {data_in, r_sreg[WIDTH-1:1]};
  assign w_take         = r_valid & data_ready;

  dram_bit_counter #(
    .N(WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .rst_b  (rst_b),
    .i_clear(clear),
    .i_inc  (w_data_bit),
    .o_count(w_count),
    .o_wrap (w_wrap)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= DATA;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_complete   = 1'b0;
    w_word       = w_sreg_shifted;
    if (clear) begin
      w_state_next = DATA;
    end else if (w_accept) begin
      case (r_state)
        DATA: begin
          if (w_wrap) begin
`ifdef DRAM_SIPO_PARITY_EN
            w_state_next = PARITY;
`else
            w_complete   = 1'b1;
`endif
          end
        end
        PARITY: begin
          // The parity bit is not shifted in; the assembled word is already in the shift register.
`ifdef DRAM_SIPO_PARITY_EN
          w_complete   = 1'b1;
          w_word       = r_sreg;
`endif
          w_state_next = DATA;
        end
        default: w_state_next = DATA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_sreg <= '0;
    end else if (clear) begin
      r_sreg <= '0;
    end else if (w_data_bit) begin
      r_sreg <= w_sreg_shifted;
    end
  end

  // A completed word may replace the held word only if the consumer takes it in the same cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_complete) begin
      if (!r_valid || data_ready) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (w_take) begin
      r_valid <= 1'b0;
    end
  end

`ifdef DRAM_SIPO_PARITY_EN
  logic                      r_perr;
  logic                      w_perr;
  logic [SIPO_MAX_WIDTH-1:0] w_word_ext;

  always_comb begin
    w_word_ext             = '0;
    w_word_ext[WIDTH-1:0]  = w_word;
    w_perr                 = even_parity(w_word_ext, data_in);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_perr <= 1'b0;
    end else if (clear) begin
      r_perr <= 1'b0;
    end else if (w_complete && (!r_valid || data_ready)) begin
      r_perr <= w_perr;
    end
  end

  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign overrun    = r_overrun;
  assign busy       = (w_count != '0) | (r_state == PARITY);

endmodule

// File: tb/tb_dram_sipo_rx.sv
// Scoreboard bench for dram_sipo_rx: directed words are queued as sent and checked on each handshake.
// Parity scenarios run when DRAM_SIPO_PARITY_EN is defined.
module tb_dram_sipo_rx;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       clear = 1'b0;
  logic       shift = 1'b0;
  logic       data_in = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       overrun;
  logic       parity_err;

  int         nCompared = 0;
  int         nMismatch = 0;
  logic [8:0] expQ[$];

  dram_sipo_rx #(
    .WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .clear     (clear),
    .shift     (shift),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .busy      (busy),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic b);
    shift   = 1'b1;
    data_in = b;
    @(posedge clk);
    #1;
    shift   = 1'b0;
  endtask

  // Sends one word LSB first; with parity, a correct even-parity bit follows unless pFlip inverts it.
  task automatic sendWord(input logic [7:0] w, input int gapMax, input logic pFlip,
                          input bit push, input bit readyOnLast, input bit chkBusy);
    if (push) expQ.push_back({pFlip, w});
    for (int i = 0; i < 8; i++) begin
`ifndef DRAM_SIPO_PARITY_EN
      if (i == 7 && readyOnLast) data_ready = 1'b1;
`endif
      applyStimulus(w[i]);
      if (chkBusy && i < 7) checkOutput("busy_mid_word", busy, 1);
      if (gapMax > 0 && i < 7) gap(int'($urandom_range(0, gapMax)));
    end
`ifdef DRAM_SIPO_PARITY_EN
    if (chkBusy) checkOutput("busy_parity_pending", busy, 1);
    if (gapMax > 0) gap(int'($urandom_range(0, gapMax)));
    if (readyOnLast) data_ready = 1'b1;
    applyStimulus((^w) ^ pFlip);
`endif
    if (chkBusy) checkOutput("busy_after_word", busy, 0);
  endtask

  // Monitor: every handshake must match the oldest queued word.
  always @(negedge clk) begin : monitor
    logic [8:0] expWord;
    if (rst_b && data_valid && data_ready) begin
      nCompared++;
      if (expQ.size() == 0) begin
        nMismatch++;
        $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", data_out);
      end else begin
        expWord = expQ.pop_front();
        if ({parity_err, data_out} !== expWord) begin
          nMismatch++;
          $display("[TB] FAIL handshake_word: got perr=%0b data=0x%0h, expected perr=%0b data=0x%0h",
                   parity_err, data_out, expWord[8], expWord[7:0]);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    gap(1);
    checkOutput("reset_data_out", data_out, 8'h00);
    checkOutput("reset_valid", data_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_parity_err", parity_err, 0);

    $display("[TB] back-to-back word 0xA5");
    data_ready = 1'b1;
    sendWord(8'hA5, 0, 1'b0, 1, 0, 1);
    checkOutput("a5_valid", data_valid, 1);
    checkOutput("a5_data", data_out, 8'hA5);
    gap(1);
    checkOutput("a5_valid_one_cycle", data_valid, 0);

    $display("[TB] word 0xA5 with random gaps");
    sendWord(8'hA5, 3, 1'b0, 1, 0, 1);
    checkOutput("a5_gap_valid", data_valid, 1);
    checkOutput("a5_gap_data", data_out, 8'hA5);
    gap(1);

    $display("[TB] overrun with consumer stalled");
    data_ready = 1'b0;
    sendWord(8'h3C, 1, 1'b0, 1, 0, 0);
    checkOutput("hold_3c_valid", data_valid, 1);
    checkOutput("hold_3c_overrun", overrun, 0);
    sendWord(8'hFF, 0, 1'b0, 0, 0, 0);
    checkOutput("ovr_data_kept", data_out, 8'h3C);
    checkOutput("ovr_flag", overrun, 1);
    data_ready = 1'b1;
    gap(1);
    checkOutput("ovr_consumed_valid", data_valid, 0);
    gap(2);
    checkOutput("ovr_sticky", overrun, 1);
    checkOutput("ovr_data_after_accept", data_out, 8'h3C);
    clear = 1'b1;
    gap(1);
    clear = 1'b0;
    checkOutput("clear_overrun", overrun, 0);

    $display("[TB] accept and complete in the same cycle");
    data_ready = 1'b0;
    sendWord(8'h11, 0, 1'b0, 1, 0, 0);
    checkOutput("hold_11", data_out, 8'h11);
    sendWord(8'h22, 1, 1'b0, 1, 1, 0);
    checkOutput("swap_data", data_out, 8'h22);
    checkOutput("swap_valid", data_valid, 1);
    checkOutput("swap_overrun", overrun, 0);
    gap(1);
    checkOutput("swap_drained", data_valid, 0);

    $display("[TB] clear during a partial word");
    applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b1);
    applyStimulus(1'b1); applyStimulus(1'b0);
    checkOutput("partial_busy", busy, 1);
    clear   = 1'b1;
    shift   = 1'b1;
    data_in = 1'b1;
    gap(1);
    clear = 1'b0;
    shift = 1'b0;
    checkOutput("clear_busy", busy, 0);
    checkOutput("clear_valid", data_valid, 0);
    sendWord(8'h5A, 0, 1'b0, 1, 0, 1);
    checkOutput("after_clear_data", data_out, 8'h5A);
    gap(1);

    $display("[TB] reset during a partial word");
    applyStimulus(1'b0); applyStimulus(1'b1); applyStimulus(1'b1);
    applyStimulus(1'b0); applyStimulus(1'b1);
    checkOutput("partial_busy_2", busy, 1);
    rst_b = 1'b0;
    #2;
    checkOutput("async_reset_busy", busy, 0);
    rst_b = 1'b1;
    gap(1);
    checkOutput("post_reset_valid", data_valid, 0);
    checkOutput("post_reset_data", data_out, 8'h00);
    sendWord(8'h5A, 0, 1'b0, 1, 0, 1);
    checkOutput("after_reset_data", data_out, 8'h5A);
    gap(1);

`ifdef DRAM_SIPO_PARITY_EN
    $display("[TB] parity good and bad");
    sendWord(8'h07, 0, 1'b0, 1, 0, 0);
    checkOutput("parity_good_err", parity_err, 0);
    checkOutput("parity_good_valid", data_valid, 1);
    gap(1);
    sendWord(8'h07, 0, 1'b1, 1, 0, 0);
    checkOutput("parity_bad_err", parity_err, 1);
    checkOutput("parity_bad_valid", data_valid, 1);
    gap(1);
`endif

    gap(4);
    checkOutput("queue_drained", expQ.size(), 0);
    checkOutput("final_valid", data_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
